// File: rtl/sum_scale_datapath.sv
// Softmax sum/scale: registered binary adder tree (LVL cycles) plus per-lane weight multipliers (1 cycle).
// No backpressure: the tree free-runs every cycle; the multiplier stage advances only while ce=1.
module sum_scale_datapath #(
  parameter  int SIZE       = 32,
  parameter  int DIN_WIDTH  = 20,
  parameter  int W_WIDTH    = 14,
  parameter  int DOUT_WIDTH = 25,
  parameter  int PROD_SHIFT = 0,
  localparam int LVL        = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int SUM_WIDTH  = DIN_WIDTH + $clog2(SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DIN_WIDTH-1:0]  din [SIZE],
  input  logic                         ce,
  input  logic signed [W_WIDTH-1:0]    weight,
  output logic signed [SUM_WIDTH-1:0]  sum,
  output logic                         sum_valid,
  output logic signed [DOUT_WIDTH-1:0] dout [SIZE],
  output logic                         dout_valid
);
  localparam int PW = DIN_WIDTH + W_WIDTH;
  localparam int NW = 2 * SIZE;

  // Levels are held at full SUM_WIDTH and zero-padded to 2*SIZE entries, so an odd
  // leftover node simply adds zero and passes through unchanged.
  logic signed [SUM_WIDTH-1:0] stage_in [LVL][NW];
  logic signed [SUM_WIDTH-1:0] node_d   [LVL][NW];
  logic signed [SUM_WIDTH-1:0] node_q   [LVL][NW];
  logic        [LVL-1:0]       vld_d, vld_q;

  logic signed [PW-1:0]         prod    [SIZE];
  logic signed [PW-1:0]         prod_sh [SIZE];
  logic signed [DOUT_WIDTH-1:0] dout_d  [SIZE];
  logic signed [DOUT_WIDTH-1:0] dout_q  [SIZE];
  logic                         dout_vld_q;

  always_comb begin
    for (int k = 0; k < LVL; k++) begin
      for (int i = 0; i < NW; i++) begin
        stage_in[k][i] = '0;
        node_d[k][i]   = '0;
      end
    end
    for (int i = 0; i < SIZE; i++) begin
      stage_in[0][i] = SUM_WIDTH'(din[i]);
    end
    for (int k = 1; k < LVL; k++) begin
      for (int i = 0; i < NW; i++) begin
        stage_in[k][i] = node_q[k-1][i];
      end
    end
    for (int k = 0; k < LVL; k++) begin
      for (int i = 0; i < SIZE; i++) begin
        node_d[k][i] = stage_in[k][2*i] + stage_in[k][2*i+1];
      end
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int k = 1; k < LVL; k++) begin
      vld_d[k] = vld_q[k-1];
    end
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) begin
      prod[i]    = PW'(din[i]) * PW'(weight);
      prod_sh[i] = prod[i] >>> PROD_SHIFT;
      // Size cast wraps when narrower, sign-extends when wider.
      dout_d[i]  = DOUT_WIDTH'(prod_sh[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < LVL; k++) begin
        for (int i = 0; i < NW; i++) begin
          node_q[k][i] <= '0;
        end
      end
      vld_q <= '0;
    end else begin
      node_q <= node_d;
      vld_q  <= vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < SIZE; i++) begin
        dout_q[i] <= '0;
      end
      dout_vld_q <= 1'b0;
    end else if (ce) begin
      dout_q     <= dout_d;
      dout_vld_q <= in_valid;
    end
  end

  assign sum        = node_q[LVL-1][0];
  assign sum_valid  = vld_q[LVL-1];
  assign dout       = dout_q;
  assign dout_valid = dout_vld_q;

endmodule

// File: tb/tb_sum_scale_datapath.sv
// Directed bench for sum_scale_datapath: SIZE=32 and SIZE=10 instances against a per-edge history model.
module tb_sum_scale_datapath;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               in_valid;
  logic               ce;
  logic signed [13:0] weight;
  logic signed [19:0] din32 [32];
  logic signed [19:0] din10 [10];

  logic signed [24:0] sum32;
  logic               sv32;
  logic signed [24:0] dout32 [32];
  logic               dv32;
  logic signed [23:0] sum10;
  logic               sv10;
  logic signed [24:0] dout10 [10];
  logic               dv10;

  sum_scale_datapath dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din32), .ce(ce), .weight(weight),
    .sum(sum32), .sum_valid(sv32), .dout(dout32), .dout_valid(dv32)
  );

  sum_scale_datapath #(.SIZE(10)) dut10 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .din(din10), .ce(ce), .weight(weight),
    .sum(sum10), .sum_valid(sv10), .dout(dout10), .dout_valid(dv10)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Model: one record per rising edge. A sum appears LVL edges after its vector,
  // unless a reset edge fell anywhere inside that window.
  typedef struct {
    bit     rst;
    bit     vld;
    longint s32;
    longint s10;
  } rec_t;
  rec_t hist[$];

  longint exp_sum32, exp_sum10;
  bit     exp_sv32, exp_sv10;
  longint exp_dout [32];
  bit     exp_dv;

  function automatic rec_t expect_at(input int lat);
    rec_t z;
    z = '{default: 0};
    if (hist.size() < lat) return z;
    for (int j = 0; j < lat; j++) if (hist[j].rst) return z;
    return hist[lat-1];
  endfunction

  always @(posedge clk) begin
    rec_t r, e32, e10;
    longint p;
    logic signed [24:0] t;
    r.rst = !reset;
    r.vld = in_valid;
    r.s32 = 0;
    r.s10 = 0;
    for (int i = 0; i < 32; i++) r.s32 += longint'(din32[i]);
    for (int i = 0; i < 10; i++) r.s10 += longint'(din10[i]);
    hist.push_front(r);
    if (hist.size() > 8) void'(hist.pop_back());
    e32 = expect_at(5);
    e10 = expect_at(4);
    exp_sum32 = e32.s32;
    exp_sv32  = e32.vld;
    exp_sum10 = e10.s10;
    exp_sv10  = e10.vld;
    if (!reset) begin
      for (int i = 0; i < 32; i++) exp_dout[i] = 0;
      exp_dv = 1'b0;
    end else if (ce) begin
      for (int i = 0; i < 32; i++) begin
        p = longint'(din32[i]) * longint'(weight);
        t = p[24:0];
        exp_dout[i] = longint'(t);
      end
      exp_dv = in_valid;
    end
  end

  always @(negedge clk) begin
    int ln;
    if (chk_en) begin
      chk("sum32", sum32, exp_sum32);
      chk("sum_valid32", sv32, exp_sv32);
      chk("sum10", sum10, exp_sum10);
      chk("sum_valid10", sv10, exp_sv10);
      ln = 0;
      for (int i = 0; i < 32; i++) if (longint'(dout32[i]) != exp_dout[i]) ln = i;
      chk($sformatf("dout32[%0d]", ln), dout32[ln], exp_dout[ln]);
      chk("dout_valid32", dv32, exp_dv);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill32(input int v);
    for (int i = 0; i < 32; i++) din32[i] = 20'(v);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; ce = 1'b0; weight = '0;
    fill32(0);
    for (int i = 0; i < 10; i++) din10[i] = '0;
    step();
    chk_en = 1'b1;
    step(); step();
    chk("rst_sum32", sum32, 0);
    chk("rst_sv32", sv32, 0);
    chk("rst_dv32", dv32, 0);
    chk("rst_dout32_0", dout32[0], 0);
    reset = 1'b1;

    // Single all-ones vector: SIZE=10 sum after 4 edges, SIZE=32 after 5, one-cycle pulse.
    fill32(1);
    for (int i = 0; i < 10; i++) din10[i] = 20'(i);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    fill32(0);
    for (int i = 0; i < 10; i++) din10[i] = '0;
    step(); step(); step();
    chk("sum10_ramp", sum10, 45);
    chk("sv10_ramp", sv10, 1);
    chk("sv32_early", sv32, 0);
    step();
    chk("sum32_ones", sum32, 32);
    chk("sv32_ones", sv32, 1);
    step();
    chk("sv32_pulse_end", sv32, 0);

    // Extremes: no overflow at SUM_WIDTH.
    fill32(-524288);
    for (int i = 0; i < 10; i++) din10[i] = 20'(-i);
    in_valid = 1'b1;
    step();
    fill32(524287);
    step();
    in_valid = 1'b0;
    fill32(0);
    for (int i = 0; i < 10; i++) din10[i] = '0;
    step(); step();
    chk("sum10_neg", sum10, -45);
    step();
    chk("sum32_min", sum32, -16777216);
    step();
    chk("sum32_max", sum32, 16777184);
    step(); step();

    // Multiplier update, hold with ce=0, then wrap of 2^32 to 0.
    ce = 1'b1; in_valid = 1'b1; weight = -14'sd3; din32[0] = 20'sd100;
    step();
    chk("mul_dout0", dout32[0], -300);
    chk("mul_dv", dv32, 1);
    ce = 1'b0; in_valid = 1'b0; din32[0] = 20'sd7;
    step();
    chk("hold_dout0", dout32[0], -300);
    chk("hold_dv", dv32, 1);
    ce = 1'b1; din32[0] = -20'sd524288; weight = -14'sd8192;
    step();
    chk("wrap_dout0", dout32[0], 0);
    chk("wrap_dv", dv32, 0);
    din32[0] = '0;
    step(); step(); step(); step(); step();

    // Stream six vectors, reset on the third; only the post-reset ones may emerge.
    in_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 32; i++) din32[i] = 20'(k + i);
      for (int i = 0; i < 10; i++) din10[i] = 20'(k);
      reset = (k == 2) ? 1'b0 : 1'b1;
      step();
      if (k == 2) begin
        chk("flush_sum32", sum32, 0);
        chk("flush_sv32", sv32, 0);
        chk("flush_dout0", dout32[0], 0);
        chk("flush_dv", dv32, 0);
        chk("flush_sum10", sum10, 0);
        chk("flush_sv10", sv10, 0);
      end
    end
    in_valid = 1'b0;
    fill32(0);
    for (int i = 0; i < 10; i++) din10[i] = '0;
    chk("no_stale_sv32", sv32, 0);
    chk("no_stale_sv10", sv10, 0);
    step();
    chk("post_sum10", sum10, 30);
    chk("post_sv10", sv10, 1);
    step();
    chk("post_sum32", sum32, 592);
    chk("post_sv32", sv32, 1);
    for (int j = 0; j < 8; j++) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
